// File: rtl/fft_pkg.sv
// Shared constants and types for the 64-point SDF FFT pipeline.
// Holds the data/twiddle widths, the half-frame depth, the phase codes
// driven by the twiddle ROM and the complex sample type.
package fft_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 8;
  localparam int HALF_N = 32;
  localparam int PTR_W  = $clog2(HALF_N);

  // Phase code that the twiddle ROM presents alongside each sample.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_IDLE = 2'd3
  } phase_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_bf_stage_32_if.sv
// Stream interface of the SDF butterfly stage: sample input, phase code and
// twiddle from the ROM on the way in, valid-qualified samples on the way out.
interface sdf_bf_stage_32_if;

  logic                              in_valid;
  logic signed [fft_pkg::DATA_W-1:0] din_r;
  logic signed [fft_pkg::DATA_W-1:0] din_i;
  logic        [1:0]                 state;
  logic signed [fft_pkg::DATA_W-1:0] w_r;
  logic signed [fft_pkg::DATA_W-1:0] w_i;
  logic                              out_valid;
  logic signed [fft_pkg::DATA_W-1:0] dout_r;
  logic signed [fft_pkg::DATA_W-1:0] dout_i;

  // Upstream side: supplies samples, phase and twiddle, observes results.
  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  // Stage side.
  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );

endinterface

// File: rtl/cmul_q8.sv
// One-register-stage complex multiplier for Q.8 twiddles.
// Products are formed at 2*DATA_W, shifted right by FRAC_W and truncated.
// Build option SDF_ROUND_EN adds half an LSB before the shift
// (round-half-up); without it the shift truncates toward minus infinity.
module cmul_q8
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  cplx_t a,
  input  cplx_t w,
  output cplx_t p
);

  localparam int PROD_W = 2 * DATA_W;

`ifdef SDF_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND_K = PROD_W'(1) <<< (FRAC_W - 1);
`else
  localparam logic signed [PROD_W-1:0] RND_K = '0;
`endif

  logic signed [PROD_W-1:0] ar, ai, wr, wi;
  logic signed [PROD_W-1:0] sum_re, sum_im;

  // Full-width product sums, widened operands keep the sign.
  always_comb begin
    ar     = PROD_W'($signed(a.re));
    ai     = PROD_W'($signed(a.im));
    wr     = PROD_W'($signed(w.re));
    wi     = PROD_W'($signed(w.im));
    sum_re = ar * wr - ai * wi + RND_K;
    sum_im = ar * wi + ai * wr + RND_K;
  end

  // Result register: scale back to data width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p.re <= DATA_W'(sum_re >>> FRAC_W);
      p.im <= DATA_W'(sum_im >>> FRAC_W);
    end
  end

endmodule

// File: rtl/sdf_bf_stage_32.sv
// Radix-2 single-path delay-feedback butterfly stage (64-point FFT).
// A 32-entry circular delay line feeds the butterfly; in the load phase it
// captures the first half frame, in the butterfly phase it emits sums and
// stores differences, in the drain phase it emits differences times twiddle.
// Fixed two-register latency on both output paths.
// Build option SDF_ROUND_EN (in cmul_q8) selects rounding of the twiddle
// products.
module sdf_bf_stage_32
  import fft_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  sdf_bf_stage_32_if.slave bus
);

  cplx_t            mem [HALF_N];
  logic [PTR_W-1:0] ptr;

  phase_e ph;
  cplx_t  d, x, w, sum, diff, wr_data;
  logic   step;

  // Stage-1 (operand) and stage-2 (result) pipeline registers.
  logic  s1_step, s1_valid, s1_tw;
  cplx_t s1_a, s1_w;
  logic  s2_tw, out_valid_q;
  cplx_t s2_sum, prod;

  assign ph = phase_e'(bus.state);
  assign x  = '{re: bus.din_r, im: bus.din_i};
  assign w  = '{re: bus.w_r, im: bus.w_i};

  // Step decision, butterfly arithmetic and the value written back.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // otherwise synthesis infers a latch.
  always_comb begin
    step    = 1'b0;
    wr_data = '0;
    d       = mem[ptr];
    sum.re  = d.re + x.re;
    sum.im  = d.im + x.im;
    diff.re = d.re - x.re;
    diff.im = d.im - x.im;
    case (ph)
      ST_LOAD: begin
        step    = bus.in_valid;
        wr_data = x;
      end
      ST_BF: begin
        step    = bus.in_valid;
        wr_data = diff;
      end
      ST_TW: begin
        step    = 1'b1;
        wr_data = '0;
      end
      ST_IDLE: begin
        step    = 1'b0;
      end
    endcase
  end

  // Delay-line write at the pointer on each step.
  // NOTE: the storage array has no reset: a reset would force it into
  // flops; every frame rewrites each entry before it is read as valid data.
  always_ff @(posedge clk) begin
    if (rst_n && step) begin
      mem[ptr] <= wr_data;
    end
  end

  // Pointer advance and stage-1 operand capture with path select.
  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_step  <= 1'b0;
      s1_valid <= 1'b0;
      s1_tw    <= 1'b0;
    end else begin
      s1_step  <= step;
      s1_valid <= step && (ph != ST_LOAD);
      s1_tw    <= (ph == ST_TW);
      s1_a     <= (ph == ST_BF) ? sum : d;
      s1_w     <= w;
      if (step) begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  // Twiddle path stage 2: registered complex multiply.
  cmul_q8 u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s1_step && s1_tw),
    .a     (s1_a),
    .w     (s1_w),
    .p     (prod)
  );

  // Add/sub path stage 2 and output qualifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s2_tw       <= 1'b0;
      s2_sum      <= '0;
    end else begin
      out_valid_q <= s1_valid;
      if (s1_step) begin
        s2_tw  <= s1_tw;
        s2_sum <= s1_a;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_r    = s2_tw ? prod.re : s2_sum.re;
  assign bus.dout_i    = s2_tw ? prod.im : s2_sum.im;

endmodule

// File: tb/tb_sdf_bf_stage_32.sv
// Self-checking bench for sdf_bf_stage_32: directed frames (impulse,
// constant, quarter twiddle, rounding, gaps, mid-frame reset) plus random
// frames, all compared against a frame-level reference model.
module tb_sdf_bf_stage_32;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdf_bf_stage_32_if bus ();

  sdf_bf_stage_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SDF_ROUND_EN
  localparam longint RND = 128;
`else
  localparam longint RND = 0;
`endif

  typedef struct {
    int     due;
    longint re;
    longint im;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     beats = 0;

  longint fx_r[64], fx_i[64], fw_r[32], fw_i[32];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic longint wrap24(input longint v);
    logic signed [23:0] t;
    t = v[23:0];
    return longint'(t);
  endfunction

  function automatic longint rnd24();
    logic [31:0] v;
    v = $urandom;
    return wrap24(longint'(v));
  endfunction

  // Q.8 complex multiply as plain integer arithmetic.
  function automatic void cmul_ref(input longint ar, ai, wr, wi,
                                   output longint re, im);
    re = wrap24((ar * wr - ai * wi + RND) >>> 8);
    im = wrap24((ar * wi + ai * wr + RND) >>> 8);
  endfunction

  // Monitor: samples 1 time unit after each edge.
  always begin
    logic r;
    @(posedge clk);
    cyc++;
    r = rst_n;
    #1;
    if (!r) begin
      check("rst_valid", bus.out_valid, 0);
      check("rst_dout_r", bus.dout_r, 0);
      check("rst_dout_i", bus.dout_i, 0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("out_valid", bus.out_valid, 1);
      check("dout_r", bus.dout_r, exp_q[0].re);
      check("dout_i", bus.dout_i, exp_q[0].im);
      void'(exp_q.pop_front());
      beats++;
    end else begin
      check("no_valid", bus.out_valid, 0);
    end
  end

  // One input cycle; optionally registers the expected output two edges on.
  task automatic drive(input phase_e st, input logic iv,
                       input longint dr, di, wr, wi,
                       input bit push, input longint er, ei);
    @(negedge clk);
    bus.state    = st;
    bus.in_valid = iv;
    bus.din_r    = dr[23:0];
    bus.din_i    = di[23:0];
    bus.w_r      = wr[23:0];
    bus.w_i      = wi[23:0];
    if (push) exp_q.push_back('{cyc + 2, er, ei});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(ST_IDLE, 1'($urandom), rnd24(), rnd24(), rnd24(), rnd24(), 0, 0, 0);
  endtask

  task automatic gap(input bit en, input phase_e st);
    if (en) begin
      while ($urandom_range(0, 2) == 0)
        drive(st, 1'b0, rnd24(), rnd24(), rnd24(), rnd24(), 0, 0, 0);
    end
  endtask

  // Full frame from fx/fw with the frame-level model:
  // sums x[n]+x[n+32] then (x[n]-x[n+32])*w[n]; 64 valid beats expected.
  task automatic run_frame(input bit gaps);
    longint tr, ti;
    beats = 0;
    for (int n = 0; n < 32; n++) begin
      gap(gaps, ST_LOAD);
      drive(ST_LOAD, 1'b1, fx_r[n], fx_i[n], rnd24(), rnd24(), 0, 0, 0);
    end
    for (int n = 0; n < 32; n++) begin
      gap(gaps, ST_BF);
      drive(ST_BF, 1'b1, fx_r[n+32], fx_i[n+32], rnd24(), rnd24(), 1,
            wrap24(fx_r[n] + fx_r[n+32]), wrap24(fx_i[n] + fx_i[n+32]));
    end
    for (int n = 0; n < 32; n++) begin
      cmul_ref(wrap24(fx_r[n] - fx_r[n+32]), wrap24(fx_i[n] - fx_i[n+32]),
               fw_r[n], fw_i[n], tr, ti);
      drive(ST_TW, gaps ? 1'b0 : 1'($urandom), rnd24(), rnd24(),
            fw_r[n], fw_i[n], 1, tr, ti);
    end
    idle(4);
    check("frame_beats", beats, 64);
  endtask

  task automatic clear_frame();
    for (int n = 0; n < 64; n++) begin fx_r[n] = 0; fx_i[n] = 0; end
    for (int n = 0; n < 32; n++) begin fw_r[n] = 256; fw_i[n] = 0; end
  endtask

  initial begin
    bus.state = ST_IDLE; bus.in_valid = 1'b0;
    bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Impulse.
    clear_frame(); fx_r[0] = 256;
    run_frame(0);
    // Constant input, plain and with gaps.
    clear_frame();
    for (int n = 0; n < 64; n++) fx_r[n] = 256;
    run_frame(0);
    run_frame(1);
    // Quarter twiddle at drain index 16.
    clear_frame(); fx_r[16] = 256; fw_r[16] = 0; fw_i[16] = -256;
    run_frame(0);
    // Rounding corner at drain index 1.
    clear_frame(); fx_r[1] = 1; fw_r[1] = 255; fw_i[1] = -25;
    run_frame(0);

    // Mid-frame reset at butterfly index 10, then a fresh constant frame.
    clear_frame();
    for (int n = 0; n < 64; n++) fx_r[n] = 256;
    for (int n = 0; n < 32; n++)
      drive(ST_LOAD, 1'b1, fx_r[n], fx_i[n], 0, 0, 0, 0, 0);
    for (int n = 0; n < 10; n++)
      drive(ST_BF, 1'b1, 256, 0, 0, 0, 1, 512, 0);
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    rst_n = 1'b0;
    bus.state = ST_BF; bus.in_valid = 1'b1; bus.din_r = 24'd256; bus.din_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.state = ST_IDLE;
    idle(2);
    run_frame(0);

    // Random frames, with and without gaps.
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < 64; n++) begin fx_r[n] = rnd24(); fx_i[n] = rnd24(); end
      for (int n = 0; n < 32; n++) begin
        if (f < 3) begin
          fw_r[n] = $signed($urandom_range(0, 512)) - 256;
          fw_i[n] = $signed($urandom_range(0, 512)) - 256;
        end else begin
          fw_r[n] = rnd24(); fw_i[n] = rnd24();
        end
      end
      run_frame(f[0]);
    end

    idle(4);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
